// File: rtl/led_sequencer.sv
// led_sequencer: pattern scheduler for the four green LEDs (LEDG).
// A prescaler produces one pattern step every TICK_DIV cycles of CLOCK_50.
// An IDLE/RUN/PAUSE controller latches the pattern on a START rising edge,
// steps it on each prescaler wrap, freezes it while HOLD is high and clears
// it while STOP is high.
// Optional build macro: LEDSEQ_AUTOSTOP_EN. When it is defined, a run ends by
// itself on the RUN_TICKS-th tick, and that end is flagged with a one-cycle
// DONE pulse. When it is undefined, DONE is tied low and a run only ends on
// STOP or reset.

module led_sequencer #(
   parameter int TICK_DIV  = 25000000,
   parameter int RUN_TICKS = 16
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic [1:0] MODE,
   input  logic       START,
   input  logic       STOP,
   input  logic       HOLD,
   output logic [3:0] LEDG,
   output logic       BUSY,
   output logic       TICK,
   output logic       DONE
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] MODE_BLINK  = 2'b00;
   localparam logic [1:0] MODE_CHASE  = 2'b01;
   localparam logic [1:0] MODE_COUNT  = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   // Out-of-range parameters leave a clearly named, empty scope in the
   // elaborated hierarchy so a bad configuration is easy to spot.
   if (TICK_DIV < 2 || RUN_TICKS < 1) begin : g_param_range_violation
   end

   state_t          state;
   logic [PW-1:0]   prescaler;
   logic [1:0]      mode_q;
   logic            start_hist;
   logic            bounce_up;
   logic            start_edge;

`ifdef LEDSEQ_AUTOSTOP_EN
   localparam int CW = $clog2(RUN_TICKS + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(RUN_TICKS - 1);
   logic [CW-1:0]   tick_count;
   logic            done_q;
`endif

   // First value shown when a run starts in the given mode.
   function automatic logic [3:0] initial_pattern(input logic [1:0] m);
      logic [3:0] p;
      p = 4'b0000;
      case (m)
         MODE_BLINK:  p = 4'b1111;
         MODE_CHASE:  p = 4'b0001;
         MODE_COUNT:  p = 4'b0000;
         MODE_BOUNCE: p = 4'b0001;
         default:     p = 4'b0000;
      endcase
      return p;
   endfunction

   // Bounce direction after a step: turn around at either end of the bar.
   function automatic logic next_direction(input logic [3:0] led, input logic up);
      logic d;
      d = up;
      if (led == 4'b1000) begin
         d = 1'b0;
      end else if (led == 4'b0001) begin
         d = 1'b1;
      end
      return d;
   endfunction

   // Next pattern value for the latched mode.
   function automatic logic [3:0] next_pattern(input logic [1:0] m,
                                               input logic [3:0] led,
                                               input logic up);
      logic [3:0] p;
      logic       d;
      p = led;
      d = next_direction(led, up);
      case (m)
         MODE_BLINK:  p = ~led;
         MODE_CHASE:  p = {led[2:0], led[3]};
         MODE_COUNT:  p = led + 4'd1;
         MODE_BOUNCE: p = d ? {led[2:0], 1'b0} : {1'b0, led[3:1]};
         default:     p = led;
      endcase
      return p;
   endfunction

   assign start_edge = START & ~start_hist;

   // Controller: reset, then STOP, then start edge, then HOLD, then the
   // prescaler tick, in that order of precedence each cycle. Leaving PAUSE
   // also counts that cycle on the prescaler so a HOLD of n cycles delays
   // the following steps by exactly n cycles.
   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         state      <= IDLE;
         LEDG       <= 4'b0000;
         BUSY       <= 1'b0;
         TICK       <= 1'b0;
         prescaler  <= '0;
         mode_q     <= 2'b00;
         start_hist <= 1'b1;
         bounce_up  <= 1'b1;
`ifdef LEDSEQ_AUTOSTOP_EN
         tick_count <= '0;
         done_q     <= 1'b0;
`endif
      end else begin
         start_hist <= START;
         TICK       <= 1'b0;
`ifdef LEDSEQ_AUTOSTOP_EN
         done_q     <= 1'b0;
`endif
         if (STOP) begin
            state     <= IDLE;
            LEDG      <= 4'b0000;
            BUSY      <= 1'b0;
            prescaler <= '0;
`ifdef LEDSEQ_AUTOSTOP_EN
            tick_count <= '0;
`endif
         end else if (start_edge) begin
            mode_q    <= MODE;
            LEDG      <= initial_pattern(MODE);
            BUSY      <= 1'b1;
            prescaler <= '0;
            bounce_up <= 1'b1;
            state     <= HOLD ? PAUSE : RUN;
`ifdef LEDSEQ_AUTOSTOP_EN
            tick_count <= '0;
`endif
         end else if (state == IDLE) begin
            LEDG <= 4'b0000;
            BUSY <= 1'b0;
         end else if (HOLD) begin
            state <= PAUSE;
         end else begin
            state <= RUN;
            if (prescaler == PRESC_MAX) begin
               prescaler <= '0;
`ifdef LEDSEQ_AUTOSTOP_EN
               if (tick_count == LAST_STEP) begin
                  state      <= IDLE;
                  LEDG       <= 4'b0000;
                  BUSY       <= 1'b0;
                  tick_count <= '0;
                  done_q     <= 1'b1;
               end else begin
                  tick_count <= tick_count + 1'b1;
                  LEDG       <= next_pattern(mode_q, LEDG, bounce_up);
                  bounce_up  <= next_direction(LEDG, bounce_up);
                  TICK       <= 1'b1;
               end
`else
               LEDG      <= next_pattern(mode_q, LEDG, bounce_up);
               bounce_up <= next_direction(LEDG, bounce_up);
               TICK      <= 1'b1;
`endif
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end
      end
   end

`ifdef LEDSEQ_AUTOSTOP_EN
   assign DONE = done_q;
`else
   assign DONE = 1'b0;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed bench for led_sequencer with TICK_DIV=4 and
// RUN_TICKS=3. Stimulus tasks push every expected pattern step (edge number,
// LEDG value, DONE flag) into a queue; a monitor pops and compares whenever
// the DUT raises TICK or DONE. State checks (reset, BUSY, frozen LEDG) are
// made directly by the stimulus.

module tb_led_sequencer;

   localparam int TICK_DIV  = 4;
   localparam int RUN_TICKS = 3;

   logic       CLOCK_50;
   logic       RST_N;
   logic [1:0] MODE;
   logic       START;
   logic       STOP;
   logic       HOLD;
   logic [3:0] LEDG;
   logic       BUSY;
   logic       TICK;
   logic       DONE;

   typedef struct {
      int         edge_at;
      logic [3:0] ledg;
      logic       done;
   } exp_t;

   exp_t       expq[$];
   logic [3:0] plan[$];
   int         edge_no = 0;
   int         checks  = 0;
   int         errors  = 0;

   led_sequencer #(
      .TICK_DIV (TICK_DIV),
      .RUN_TICKS(RUN_TICKS)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RST_N   (RST_N),
      .MODE    (MODE),
      .START   (START),
      .STOP    (STOP),
      .HOLD    (HOLD),
      .LEDG    (LEDG),
      .BUSY    (BUSY),
      .TICK    (TICK),
      .DONE    (DONE)
   );

   // 50 MHz board clock.
   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   // Edge counter used to time-stamp expected steps.
   always @(posedge CLOCK_50) begin
      edge_no <= edge_no + 1;
   end

   // Monitor: every TICK or DONE pulse must match the oldest expected step.
   always @(negedge CLOCK_50) begin
      if (TICK === 1'b1 || DONE === 1'b1) begin
         exp_t e;
         checks = checks + 1;
         if (expq.size() == 0) begin
            errors = errors + 1;
            $display("[TB] FAIL unexpected_step edge %0d LEDG %b TICK %b DONE %b, required no step",
                     edge_no, LEDG, TICK, DONE);
         end else begin
            e = expq.pop_front();
            if (edge_no != e.edge_at || LEDG !== e.ledg || DONE !== e.done || TICK !== !e.done) begin
               errors = errors + 1;
               $display("[TB] FAIL step edge %0d LEDG %b TICK %b DONE %b, required edge %0d LEDG %b TICK %b DONE %b",
                        edge_no, LEDG, TICK, DONE, e.edge_at, e.ledg, !e.done, e.done);
            end
         end
      end
   end

   // Watchdog so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout at edge %0d, required normal finish", edge_no);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
      checks = checks + 1;
      if (actual !== required) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual %b required %b", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic start, input logic stop, input logic hold);
      MODE  = m;
      START = start;
      STOP  = stop;
      HOLD  = hold;
   endtask

   task automatic waitToEdge(input int target);
      while (edge_no < target) @(negedge CLOCK_50);
   endtask

   // Raise START at a negedge; the run starts at edge k, START drops after it.
   task automatic startRun(input logic [1:0] m, input logic hold, output int k);
      applyStimulus(m, 1'b1, 1'b0, hold);
      k = edge_no + 1;
      @(negedge CLOCK_50);
      START = 1'b0;
   endtask

   // Queue the planned steps of a run started at edge k, each late by delay.
   task automatic pushRun(input int k, input int delay);
      exp_t e;
      for (int i = 0; i < plan.size(); i++) begin
         e.edge_at = k + TICK_DIV * (i + 1) + delay;
`ifdef LEDSEQ_AUTOSTOP_EN
         if (i + 1 == RUN_TICKS) begin
            e.ledg = 4'b0000;
            e.done = 1'b1;
            expq.push_back(e);
            break;
         end
`endif
         e.ledg = plan[i];
         e.done = 1'b0;
         expq.push_back(e);
      end
   endtask

   task automatic doStop(input string name);
      STOP = 1'b1;
      @(negedge CLOCK_50);
      checkOutput({name, "_ledg"}, {4'b0, LEDG}, 8'h00);
      checkOutput({name, "_busy"}, {7'b0, BUSY}, 8'h00);
      STOP = 1'b0;
   endtask

   initial begin
      int k;
      int k2;
      int k3;
      RST_N = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge CLOCK_50);
      checkOutput("reset_ledg", {4'b0, LEDG}, 8'h00);
      checkOutput("reset_flags", {5'b0, BUSY, TICK, DONE}, 8'h00);
      RST_N = 1'b1;
      @(negedge CLOCK_50);

      // Chase: steps every 4 edges after the start edge.
      startRun(2'b01, 1'b0, k);
      checkOutput("chase_init", {3'b0, BUSY, LEDG}, 8'h11);
      plan = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pushRun(k, 0);
      waitToEdge(k + 17);
`ifdef LEDSEQ_AUTOSTOP_EN
      checkOutput("autostop_busy", {7'b0, BUSY}, 8'h00);
`endif
      doStop("chase_stop");

      // Bounce over eight ticks.
      startRun(2'b11, 1'b0, k);
      checkOutput("bounce_init", {4'b0, LEDG}, 8'h01);
      plan = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
      pushRun(k, 0);
      waitToEdge(k + 33);
      doStop("bounce_stop");

      // Count through the wrap 1111 -> 0000.
      startRun(2'b10, 1'b0, k);
      checkOutput("count_init", {3'b0, BUSY, LEDG}, 8'h10);
      plan.delete();
      for (int i = 1; i <= 16; i++) plan.push_back(4'(i));
      pushRun(k, 0);
      waitToEdge(k + 65);
      doStop("count_stop");

      // Blink with HOLD for 5 cycles at prescaler 2.
      startRun(2'b00, 1'b0, k);
      checkOutput("blink_init", {4'b0, LEDG}, 8'h0F);
      waitToEdge(k + 2);
      HOLD = 1'b1;
      plan = '{4'b0000, 4'b1111};
      pushRun(k, 5);
      waitToEdge(k + 5);
      checkOutput("hold_frozen", {3'b0, BUSY, LEDG}, 8'h1F);
      waitToEdge(k + 7);
      HOLD = 1'b0;
      waitToEdge(k + 14);
      doStop("blink_stop");

      // STOP and a START rising edge in the same cycle: STOP wins.
      startRun(2'b01, 1'b0, k);
      waitToEdge(k + 1);
      applyStimulus(2'b01, 1'b1, 1'b1, 1'b0);
      @(negedge CLOCK_50);
      checkOutput("stop_start_same", {3'b0, BUSY, LEDG}, 8'h00);
      STOP = 1'b0;
      repeat (6) @(negedge CLOCK_50);
      checkOutput("start_consumed", {3'b0, BUSY, LEDG}, 8'h00);
      START = 1'b0;
      @(negedge CLOCK_50);

      // START held through reset does not start a run.
      START = 1'b1;
      RST_N = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      RST_N = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      checkOutput("start_thru_reset", {3'b0, BUSY, LEDG}, 8'h00);
      START = 1'b0;
      @(negedge CLOCK_50);
      startRun(2'b10, 1'b0, k);
      checkOutput("toggle_start", {3'b0, BUSY, LEDG}, 8'h10);
      plan = '{4'b0001};
      pushRun(k, 0);
      // Restart mid-run with a new mode: prescaler restarts from 0.
      waitToEdge(k + 5);
      startRun(2'b01, 1'b0, k2);
      checkOutput("restart_mid", {3'b0, BUSY, LEDG}, 8'h11);
      // Restart on a prescaler wrap edge: no TICK, new pattern.
      waitToEdge(k2 + 3);
      startRun(2'b00, 1'b0, k3);
      checkOutput("restart_on_wrap", {2'b0, TICK, BUSY, LEDG}, 8'h1F);
      plan = '{4'b0000, 4'b1111};
      pushRun(k3, 0);
      waitToEdge(k3 + 9);
      doStop("restart_stop");

      repeat (2) @(negedge CLOCK_50);
      checkOutput("steps_left", 8'(expq.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Pattern scheduler for the four green LEDs on the 50 MHz board clock. A prescaler generates a pattern tick every TICK_DIV cycles. A three-state controller (IDLE/RUN/PAUSE) selects and steps one of four LED patterns and owns start, stop and hold sequencing. It replaces free-running single-pattern blinkers as the sole driver of LEDG.

## Interface
- TICK_DIV, 25000000: clock cycles per pattern tick (≥2); prescaler width = $clog2(TICK_DIV).
- RUN_TICKS, 16: ticks per run before auto-stop (≥1); used only with LEDSEQ_AUTOSTOP_EN.
- CLOCK_50  in  1  board clock; all logic on posedge.
- RST_N  in  1  synchronous, active-low reset.
- MODE  in  2  pattern select: 00 blink, 01 chase, 10 count, 11 bounce; latched on start.
- START  in  1  level input (synchronous, debounced upstream); a rising edge starts or restarts a run.
- STOP  in  1  level; while high, forces IDLE.
- HOLD  in  1  level; while high, freezes the run (PAUSE).
- LEDG  out  4  registered LED pattern.
- BUSY  out  1  registered; 1 in RUN or PAUSE.
- TICK  out  1  registered one-cycle pulse, coincident with each LEDG pattern step.
- DONE  out  1  registered one-cycle pulse on auto-stop; constant 0 without the macro.

## Operation
- Reset (RST_N=0 at an edge): state IDLE, LEDG=0000, BUSY=0, TICK=0, DONE=0, prescaler=0, tick counter=0, mode register=00, START history register=1. START held high through reset does not trigger a run.
- Start edge = START=1 while the history register is 0; the history register takes START every cycle.
- Priority each cycle: reset > STOP > start edge > HOLD > tick.
- STOP=1: state IDLE, LEDG=0000, prescaler=0, tick counter=0. No TICK or DONE.
- Start edge (STOP=0), from any state:
  - latch MODE; LEDG=initial pattern; prescaler=0; tick counter=0.
  - next state is PAUSE if HOLD=1, otherwise RUN.
- RUN with HOLD=1 goes to PAUSE. PAUSE with HOLD=0 goes to RUN.
- PAUSE freezes the prescaler and LEDG.
- RUN: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0, and LEDG steps to the next pattern with TICK=1.
- Patterns, initial value first:
  - blink: 1111 ↔ 0000.
  - chase: one-hot rotate left, 0001→0010→0100→1000→0001.
  - count: 0000 incrementing mod 16 (1111→0000).
  - bounce: 0001,0010,0100,1000,0100,0010,0001,0010… The direction bit reverses at 1000 and at 0001. The initial direction is up.
- MODE changes during a run are ignored until the next start edge.
- IDLE holds LEDG=0000. HOLD has no effect in IDLE.

## Timing
- Start edge sampled at edge k: at edge k, LEDG=initial value and BUSY=1.
- With HOLD=0 throughout, pattern steps land at edges k+TICK_DIV, k+2·TICK_DIV, …
- TICK and DONE go high for exactly one cycle, in the same cycle as the corresponding LEDG update.
- HOLD=1 for n cycles during RUN delays every later step by exactly n cycles. The prescaler value is preserved.
- STOP takes effect at the sampling edge: LEDG=0000 and BUSY=0 after that edge, with zero extra latency.
- A start edge and STOP in the same cycle: STOP wins. The start edge is consumed (history register updates) and no run begins.
- A start edge in the same cycle as a prescaler wrap: the restart wins, with no TICK and prescaler=0.

## Configuration
- LEDSEQ_AUTOSTOP_EN defined:
  - the tick counter counts steps in RUN.
  - on the tick where the counter reaches RUN_TICKS, no pattern step occurs; instead state goes to IDLE, LEDG=0000, BUSY=0, DONE=1, TICK=0.
  - a run therefore shows RUN_TICKS-1 steps after the initial pattern.
- Undefined: the tick counter and its logic are absent. DONE is tied to 0, and runs continue until STOP or reset.

## Test plan
Bench uses TICK_DIV=4, RUN_TICKS=3.
- Reset, then start edge with MODE=01, HOLD=0 → LEDG 0001 at edge k, 0010 at k+4, 0100 at k+8, 1000 at k+12, 0001 at k+16; TICK high only at those step edges.
- MODE=11, run 8 ticks → LEDG sequence 0001,0010,0100,1000,0100,0010,0001,0010,0100. MODE=10 from 1111 → 0000.
- Start with MODE=00, HOLD=1 for 5 cycles at prescaler=2 → LEDG frozen at 1111 and BUSY=1. After HOLD drops, the step to 0000 occurs 5 cycles later than unpaused.
- STOP and START rising in the same cycle during RUN → IDLE, LEDG=0000, BUSY=0. Dropping STOP while START stays high does not start a run.
- START held high across reset release → state stays IDLE. A low-then-high toggle starts a run. A second start edge mid-run reinitialises LEDG with prescaler=0.
- LEDSEQ_AUTOSTOP_EN, MODE=01 → steps 0001, 0010 at k+4, 0100 at k+8. At k+12: LEDG=0000, DONE=1 for one cycle, BUSY=0. Without the macro, DONE stays 0 and 1000 appears at k+12.
